// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the pipeline sequencing controller.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 6;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_MEM    = 2'd2;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    RUN        = 2'd1,
    LOAD_STALL = 2'd2,
    JM_WAIT    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_controller_hazard_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : hazard_detect
// Brief  : Combinational load-use compare between the ID sources and EX dest.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_wrt,
  output logic                  load_use
);

  // Register 0 compares like any other register.
  always_comb begin
    load_use = ex_mem_read & ex_reg_wrt &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipeline_controller
// Brief  : PC / IF-ID / ID-EX sequencing for load-use, redirect and jumpMem.
//          Define PIPE_CTRL_PERF_EN to add the stall/flush event counters.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_wrt,
  input  logic                  ex_branch_zero,
  input  logic                  ex_branch_neg,
  input  logic                  ex_jump,
  input  logic                  ex_jump_mem,
  input  logic                  ex_alu_zero,
  input  logic                  ex_alu_neg,
  output logic                  pc_wr_en,
  output logic [1:0]            pc_sel,
  output logic                  if_id_wr_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [1:0] c_stall_load = 2'(STALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       w_taken;
  logic       w_load_use;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_reg_wrt  (ex_reg_wrt),
    .load_use    (w_load_use)
  );

  always_comb begin
    w_taken = ex_jump | (ex_branch_zero & ex_alu_zero) | (ex_branch_neg & ex_alu_neg);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_wr_en     = 1'b1;
    pc_sel       = PC_SEL_SEQ;
    if_id_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      FILL: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        // Redirects outrank load-use: the ID instruction is flushed anyway.
        if (w_taken) begin
          pc_sel       = PC_SEL_BRANCH;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ex_jump_mem) begin
          pc_wr_en     = 1'b0;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = JM_WAIT;
        end else if (w_load_use) begin
          pc_wr_en     = 1'b0;
          if_id_wr_en  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = c_stall_load;
          state_d      = (STALL_CYCLES == 1) ? RUN : LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        pc_wr_en     = 1'b0;
        if_id_wr_en  = 1'b0;
        id_ex_bubble = 1'b1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      JM_WAIT: begin
        pc_sel       = PC_SEL_MEM;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      default: state_d = FILL;
    endcase
    if (reset) begin
      pc_wr_en     = 1'b1;
      pc_sel       = PC_SEL_SEQ;
      if_id_wr_en  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = FILL;
      cnt_d        = 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state_q == RUN) begin
      assert (!(w_taken && ex_jump_mem));
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic        w_stall_evt;
  logic        w_flush_evt;

  always_comb begin
    w_flush_evt = !reset && state_q == RUN && (w_taken || ex_jump_mem);
    w_stall_evt = !reset && ((state_q == LOAD_STALL) ||
                  (state_q == RUN && !w_taken && !ex_jump_mem && w_load_use));
    stall_d     = (w_stall_evt && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
    flush_d     = (w_flush_evt && flush_q != 32'hFFFF_FFFF) ? flush_q + 32'd1 : flush_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_pipeline_controller
// Brief  : Directed vector table, hand sequences and random run vs. a model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

  localparam int STALL = 2;

  // Expected outputs packed as {pc_wr_en, pc_sel[1:0], if_id_wr_en, flush, bubble}
  localparam logic [5:0] E_FILL  = 6'b1_00_1_1_1;
  localparam logic [5:0] E_RUN   = 6'b1_00_1_0_0;
  localparam logic [5:0] E_STALL = 6'b0_00_0_0_1;
  localparam logic [5:0] E_TAKEN = 6'b1_01_1_1_1;
  localparam logic [5:0] E_JM0   = 6'b0_00_1_1_1;
  localparam logic [5:0] E_JM1   = 6'b1_10_1_1_1;
  // EX controls packed as {mem_read, reg_wrt, br_zero, br_neg, jump, jump_mem, alu_zero, alu_neg}
  localparam logic [7:0] C_LD    = 8'b1100_0000;

  typedef struct {
    logic       rst;
    logic [5:0] rs;
    logic [5:0] rt;
    logic [5:0] rd;
    logic [1:0] uses;
    logic [7:0] ctl;
    logic [5:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_mem_read, ex_reg_wrt, ex_branch_zero, ex_branch_neg;
  logic        ex_jump, ex_jump_mem, ex_alu_zero, ex_alu_neg;
  logic        pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble;
  logic [1:0]  pc_sel;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending penalty cycles rather than FSM states.
  int          m_fill = 1;
  int          m_stall_left = 0;
  int          m_jm = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  always #5 clock = ~clock;

  pipeline_controller #(.STALL_CYCLES(STALL)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_wrt     (ex_reg_wrt),
    .ex_branch_zero (ex_branch_zero),
    .ex_branch_neg  (ex_branch_neg),
    .ex_jump        (ex_jump),
    .ex_jump_mem    (ex_jump_mem),
    .ex_alu_zero    (ex_alu_zero),
    .ex_alu_neg     (ex_alu_neg),
    .pc_wr_en       (pc_wr_en),
    .pc_sel         (pc_sel),
    .if_id_wr_en    (if_id_wr_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  function automatic bit m_taken();
    return ex_jump | (ex_branch_zero & ex_alu_zero) | (ex_branch_neg & ex_alu_neg);
  endfunction

  function automatic bit m_lu();
    return ex_mem_read && ex_reg_wrt &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  function automatic logic [5:0] model_expect();
    if (reset || m_fill != 0)  return E_FILL;
    if (m_jm != 0)             return E_JM1;
    if (m_stall_left > 0)      return E_STALL;
    if (m_taken())             return E_TAKEN;
    if (ex_jump_mem)           return E_JM0;
    if (m_lu())                return E_STALL;
    return E_RUN;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_fill = 1; m_stall_left = 0; m_jm = 0; m_sc = 0; m_fc = 0;
    end else if (m_fill != 0) begin
      m_fill = 0;
    end else if (m_jm != 0) begin
      m_jm = 0;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
      if (m_sc != 32'hFFFF_FFFF) m_sc++;
    end else if (m_taken()) begin
      if (m_fc != 32'hFFFF_FFFF) m_fc++;
    end else if (ex_jump_mem) begin
      m_jm = 1;
      if (m_fc != 32'hFFFF_FFFF) m_fc++;
    end else if (m_lu()) begin
      m_stall_left = STALL - 1;
      if (m_sc != 32'hFFFF_FFFF) m_sc++;
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    id_rs = v.rs;
    id_rt = v.rt;
    ex_rd = v.rd;
    {id_uses_rs, id_uses_rt} = v.uses;
    {ex_mem_read, ex_reg_wrt, ex_branch_zero, ex_branch_neg,
     ex_jump, ex_jump_mem, ex_alu_zero, ex_alu_neg} = v.ctl;
  endtask

  // One clock: check outputs at the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic [5:0] exp_in, input bit use_model, input string name);
    logic [5:0] exp;
    logic [5:0] act;
    @(negedge clock);
    exp = use_model ? model_expect() : exp_in;
    act = {pc_wr_en, pc_sel, if_id_wr_en, if_id_flush, id_ex_bubble};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: {pcwe,pcsel,ifwe,flush,bubble} got %b expected %b",
               name, $time, act, exp);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== m_sc || flush_events !== m_fc) begin
      errors++;
      $display("FAIL %s_perf t=%0t: stall/flush got %0d/%0d expected %0d/%0d",
               name, $time, stall_cycles, flush_events, m_sc, m_fc);
    end
`endif
    model_update();
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_RUN};
    // Reset, fill, and the directed hazard scenarios in one continuous run.
    for (int i = 0; i < 3; i++) tbl.push_back(vec_t'{1'b1, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_FILL});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_FILL});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b10, C_LD, E_STALL});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_STALL});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b10, C_LD | 8'b0010_0010, E_TAKEN});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd7, 6'd7, 6'd7, 2'b01, C_LD, E_STALL});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_STALL});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'b0001_0000, E_RUN});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'b0001_0001, E_TAKEN});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'b0000_1000, E_TAKEN});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'b0000_0100, E_JM0});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_JM1});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b10, C_LD | 8'b0000_0100, E_JM0});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_JM1});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b10, C_LD, E_STALL});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_STALL});
    tbl.push_back(idle);
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b10, 8'b1000_0000, E_RUN});
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b00, C_LD, E_RUN});
    tbl.push_back(vec_t'{1'b0, 6'd5, 6'd0, 6'd5, 2'b10, C_LD | 8'b0010_0000, E_STALL});
    tbl.push_back(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_STALL});
    tbl.push_back(idle);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      step(tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset landing in LOAD_STALL with one stall cycle left.
    apply(vec_t'{1'b0, 6'd9, 6'd0, 6'd9, 2'b10, C_LD, E_STALL});
    step(E_STALL, 1'b0, "rst_stall_lu");
    apply(vec_t'{1'b1, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_FILL});
    step(E_FILL, 1'b0, "rst_stall_hold");
    apply(idle);
    step(E_FILL, 1'b0, "rst_stall_fill");
    step(E_RUN, 1'b0, "rst_stall_run");

    // Reset landing in JM_WAIT.
    apply(vec_t'{1'b0, 6'd0, 6'd0, 6'd0, 2'b00, 8'b0000_0100, E_JM0});
    step(E_JM0, 1'b0, "rst_jm_c0");
    apply(vec_t'{1'b1, 6'd0, 6'd0, 6'd0, 2'b00, 8'd0, E_FILL});
    step(E_FILL, 1'b0, "rst_jm_hold");
    apply(idle);
    step(E_FILL, 1'b0, "rst_jm_fill");
    step(E_RUN, 1'b0, "rst_jm_run");

    // Random traffic against the model; taken and jumpMem never together.
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      id_rs          = 6'($urandom_range(0, 7));
      id_rt          = 6'($urandom_range(0, 7));
      ex_rd          = 6'($urandom_range(0, 7));
      id_uses_rs     = 1'($urandom_range(0, 1));
      id_uses_rt     = 1'($urandom_range(0, 1));
      ex_mem_read    = 1'($urandom_range(0, 1));
      ex_reg_wrt     = 1'($urandom_range(0, 1));
      ex_branch_zero = ($urandom_range(0, 5) == 0);
      ex_branch_neg  = ($urandom_range(0, 5) == 0);
      ex_jump        = ($urandom_range(0, 11) == 0);
      ex_alu_zero    = 1'($urandom_range(0, 1));
      ex_alu_neg     = 1'($urandom_range(0, 1));
      ex_jump_mem    = ($urandom_range(0, 9) == 0) && !m_taken();
      step(6'd0, 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
